fact_ctrl: RTL and testbench

- Control unit for the memory-mapped factorial accelerator datapath: counter register, product register, and a multi-cycle multiplier with a start/done handshake.
- Detects a rising edge on the go bit, range-checks N, and sequences load, multiply and decrement steps until the count reaches 1.
- Reports busy/done/err status for the status register that the CPU reads back.
- Sits between the accelerator's register-interface decode and its datapath.

---
 rtl/fact_ctrl_if.sv | 31 +++
 rtl/fact_ctrl.sv | 138 +++++++++++++
 tb/tb_fact_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fact_ctrl_if.sv
// Handshake/bus bundle between the factorial controller and its
// register decode + datapath. master = decode/datapath side, slave = fact_ctrl.
interface fact_ctrl_if #(
   parameter int NW = 4
);
   logic          go;
   logic [NW-1:0] n;
   logic          cnt_gt1;
   logic          mul_done;
   logic          ld_cnt;
   logic          ld_prod;
   logic          init_prod;
   logic          dec_cnt;
   logic          mul_start;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    state;

   modport master (
      output go, n, cnt_gt1, mul_done,
      input  ld_cnt, ld_prod, init_prod, dec_cnt,
      input  mul_start, busy, done, err, state
   );

   modport slave (
      input  go, n, cnt_gt1, mul_done,
      output ld_cnt, ld_prod, init_prod, dec_cnt,
      output mul_start, busy, done, err, state
   );
endinterface

// File: rtl/fact_ctrl.sv
// Factorial accelerator control FSM: edge-detects go, range-checks n,
// sequences load / multiply / decrement until the counter reaches 1.
// Ports: clk, rst (sync, active-low), f (fact_ctrl_if.slave):
//   in  go, n, cnt_gt1, mul_done
//   out ld_cnt, ld_prod, init_prod, dec_cnt, mul_start, busy, done, err, state
// Optional: define FACT_CTRL_TIMEOUT_EN for a multiplier watchdog in WAIT.
module fact_ctrl #(
   parameter int NW      = 4,
   parameter int MAX_N   = 12,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   fact_ctrl_if.slave  f
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CHECK  = 3'd2,
      MUL    = 3'd3,
      WAIT   = 3'd4,
      UPDATE = 3'd5
   } state_t;

   state_t      st;
   state_t      nxt;
   logic        go_q;
   logic        done;
   logic        done_n;
   logic        err;
   logic        err_n;
   logic        start;
   logic        n_big;
   logic [31:0] n32;

   assign start = f.go & ~go_q;
   assign n32   = 32'(f.n);
   assign n_big = n32 > 32'(MAX_N);

`ifdef FACT_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tcnt;

   // Held at zero outside WAIT, so it is already clear on entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tcnt <= '0;
      end else if (st != WAIT) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end
`endif

   // go_q resets high so a go held through reset is not seen as an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st   <= IDLE;
         go_q <= 1'b1;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         st   <= nxt;
         go_q <= f.go;
         done <= done_n;
         err  <= err_n;
      end
   end

   always_comb begin
      nxt         = st;
      done_n      = done;
      err_n       = err;
      f.ld_cnt    = 1'b0;
      f.ld_prod   = 1'b0;
      f.init_prod = 1'b0;
      f.dec_cnt   = 1'b0;
      f.mul_start = 1'b0;
      unique case (st)
         IDLE: begin
            if (start) begin
               done_n = 1'b0;
               err_n  = 1'b0;
               if (n_big) begin
                  err_n = 1'b1;
               end else begin
                  nxt = LOAD;
               end
            end
         end
         LOAD: begin
            f.ld_cnt    = 1'b1;
            f.ld_prod   = 1'b1;
            f.init_prod = 1'b1;
            nxt         = CHECK;
         end
         CHECK: begin
            if (f.cnt_gt1) begin
               nxt = MUL;
            end else begin
               nxt    = IDLE;
               done_n = 1'b1;
            end
         end
         MUL: begin
            f.mul_start = 1'b1;
            nxt         = WAIT;
         end
         WAIT: begin
            if (f.mul_done) begin
               nxt = UPDATE;
`ifdef FACT_CTRL_TIMEOUT_EN
            end else if (tcnt == TLAST) begin
               err_n = 1'b1;
               nxt   = IDLE;
`endif
            end
         end
         UPDATE: begin
            f.ld_prod = 1'b1;
            f.dec_cnt = 1'b1;
            nxt       = CHECK;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   assign f.busy  = (st != IDLE);
   assign f.done  = done;
   assign f.err   = err;
   assign f.state = st;

endmodule

// File: tb/tb_fact_ctrl.sv
// Self-checking bench for fact_ctrl: models the counter/product/multiplier
// datapath and scores each run's result, latency and strobe counts.
module tb_fact_ctrl;
   localparam int NW      = 4;
   localparam int MAX_N   = 12;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fact_ctrl_if #(.NW(NW)) f ();

   fact_ctrl #(
      .NW(NW),
      .MAX_N(MAX_N),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .f(f)
   );

   int          cyc = 0;
   logic [3:0]  cnt = '0;
   logic [31:0] prod = '0;
   logic [31:0] mres = '0;
   logic        mdone_r = 1'b0;
   logic        tie0 = 1'b0;

   assign f.cnt_gt1  = (cnt > 4'd1);
   assign f.mul_done = mdone_r;

   // Datapath model: counter, product register, 1-cycle multiplier.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (f.ld_cnt) cnt <= f.n;
      else if (f.dec_cnt) cnt <= cnt - 4'd1;
      if (f.ld_prod) prod <= f.init_prod ? 32'd1 : mres;
      if (f.mul_start) mres <= prod * {28'd0, cnt};
      mdone_r <= f.mul_start & ~tie0;
   end

   typedef struct {
      bit          is_err;
      logic [31:0] fact;
      int          lat;
      int          nmul;
      int          ndec;
      int          nld;
      int          e0;
      int          mul0;
      int          dec0;
      int          ld0;
      int          busy0;
   } exp_t;

   exp_t sb[$];

   int nchk = 0;
   int nerr = 0;
   int tot_mul = 0;
   int tot_dec = 0;
   int tot_ld = 0;
   int tot_busy = 0;
   int excl_bad = 0;
   int both_bad = 0;
   logic done_p = 1'b0;
   logic err_p = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] factf(input int k);
      logic [31:0] r = 32'd1;
      for (int i = 2; i <= k; i++) r = r * 32'(i);
      return r;
   endfunction

   // Output monitor: pops the scoreboard on each done/err rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (f.mul_start) tot_mul++;
      if (f.dec_cnt) tot_dec++;
      if (f.ld_cnt) tot_ld++;
      if (f.busy) tot_busy++;
      if (f.mul_start & f.dec_cnt) excl_bad++;
      if (f.done & f.err) both_bad++;
      if ((f.done & ~done_p) | (f.err & ~err_p)) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("latency", 32'(cyc - e.e0), 32'(e.lat));
            chk("err", 32'(f.err), 32'(e.is_err));
            chk("done", 32'(f.done), 32'(!e.is_err));
            if (!e.is_err) chk("product", prod, e.fact);
            chk("mul_pulses", 32'(tot_mul - e.mul0), 32'(e.nmul));
            chk("dec_pulses", 32'(tot_dec - e.dec0), 32'(e.ndec));
            chk("ld_pulses", 32'(tot_ld - e.ld0), 32'(e.nld));
            chk("busy_cycles", 32'(tot_busy - e.busy0), 32'(e.lat));
            chk("busy_end", 32'(f.busy), 32'd0);
            chk("state_end", 32'(f.state), 32'd0);
         end
      end
      done_p = f.done;
      err_p  = f.err;
   end

   // tmo != 0: expect a watchdog error tmo cycles after the go edge.
   task automatic launch(input int nv, input int tmo);
      exp_t e;
      @(negedge clk);
      e.is_err = (nv > MAX_N) || (tmo != 0);
      e.fact   = factf(nv);
      if (tmo != 0) begin
         e.lat  = tmo;
         e.nmul = 1;
         e.ndec = 0;
         e.nld  = 1;
      end else if (nv > MAX_N) begin
         e.lat  = 0;
         e.nmul = 0;
         e.ndec = 0;
         e.nld  = 0;
      end else begin
         e.lat  = (nv <= 1) ? 2 : 2 + 4 * (nv - 1);
         e.nmul = (nv <= 1) ? 0 : nv - 1;
         e.ndec = e.nmul;
         e.nld  = 1;
      end
      e.e0    = cyc + 1;
      e.mul0  = tot_mul;
      e.dec0  = tot_dec;
      e.ld0   = tot_ld;
      e.busy0 = tot_busy;
      sb.push_back(e);
      f.n  = NW'(nv);
      f.go = 1'b1;
   endtask

   task automatic wait_out(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("out_timeout", 32'd1, 32'd0);
         sb.delete();
      end
   endtask

   task automatic drop_go();
      @(negedge clk);
      f.go = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int s_mul;
      int s_dec;
      int s_ld;
      int k;
      f.go = 1'b1;
      f.n  = '0;
      rst  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(f.state), 32'd0);
      chk("rst_busy", 32'(f.busy), 32'd0);
      chk("rst_done", 32'(f.done), 32'd0);
      chk("rst_err", 32'(f.err), 32'd0);
      rst = 1'b1;
      // go held high across reset release must not launch.
      repeat (10) @(negedge clk);
      chk("go_held_busy", 32'(f.busy), 32'd0);
      chk("go_held_ld", 32'(tot_ld), 32'd0);
      drop_go();

      launch(5, 0);
      wait_out(60);
      drop_go();
      launch(0, 0);
      wait_out(20);
      drop_go();
      launch(1, 0);
      wait_out(20);
      drop_go();

      launch(13, 0);
      wait_out(20);
      repeat (3) @(negedge clk);
      chk("range_busy", 32'(f.busy), 32'd0);
      chk("range_err_hold", 32'(f.err), 32'd1);
      drop_go();
      launch(12, 0);
      @(negedge clk);
      chk("err_clr", 32'(f.err), 32'd0);
      wait_out(80);
      drop_go();

      // go toggling mid-run is ignored; go high at completion no retrigger.
      launch(5, 0);
      repeat (3) @(negedge clk);
      f.go = 1'b0;
      repeat (2) @(negedge clk);
      f.go = 1'b1;
      repeat (2) @(negedge clk);
      f.go = 1'b0;
      @(negedge clk);
      f.go = 1'b1;
      wait_out(60);
      s_ld = tot_ld;
      repeat (10) @(negedge clk);
      chk("no_retrig_busy", 32'(f.busy), 32'd0);
      chk("no_retrig_ld", 32'(tot_ld - s_ld), 32'd0);
      drop_go();

      // Reset while stuck in WAIT.
      tie0 = 1'b1;
      launch(5, 0);
      k = 0;
      while (f.state != 3'd4 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("reached_wait", 32'(f.state), 32'd4);
      rst = 1'b0;
      @(negedge clk);
      sb.delete();
      chk("abort_state", 32'(f.state), 32'd0);
      chk("abort_done", 32'(f.done), 32'd0);
      chk("abort_err", 32'(f.err), 32'd0);
      chk("abort_busy", 32'(f.busy), 32'd0);
      s_mul = tot_mul;
      s_dec = tot_dec;
      s_ld  = tot_ld;
      rst   = 1'b1;
      tie0  = 1'b0;
      f.go  = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_strobes",
          32'((tot_mul - s_mul) + (tot_dec - s_dec) + (tot_ld - s_ld)),
          32'd0);
      launch(3, 0);
      wait_out(30);
      drop_go();

      for (int i = 2; i <= 4; i++) begin
         launch(i, 0);
         wait_out(30);
         drop_go();
      end

`ifdef FACT_CTRL_TIMEOUT_EN
      tie0 = 1'b1;
      launch(3, 3 + TIMEOUT);
      wait_out(TIMEOUT + 20);
      drop_go();
      tie0 = 1'b0;
      launch(3, 0);
      wait_out(30);
      drop_go();
`endif

      chk("strobe_excl", 32'(excl_bad), 32'd0);
      chk("done_err_excl", 32'(both_bad), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
